// File: rtl/spi_slave_regfile.sv
// Command/data frame decoder between the SPI slave byte engine and a small
// 8-bit register file; read-back bytes are handed to the slave transmit side.
module spi_slave_regfile #(
    parameter int NUM_REGS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic [7:0]            si_data,
    input  logic                  si_done,
    output logic [7:0]            so_data,
    output logic                  so_start,
    input  logic                  so_ready,
    output logic [8*NUM_REGS-1:0] reg_q,
    output logic                  wr_pulse,
    output logic [6:0]            wr_addr,
    output logic [7:0]            wr_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR      = 3'd2,
        RD_LOAD = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    state_t     state, state_nxt;
    logic       cs_meta, cs_sync;
    logic [1:0] sync_vld;
    logic       armed;
    logic [6:0] addr;
    logic       loaded;
    logic [7:0] regs [NUM_REGS];
    logic [7:0] rd_byte;
    logic       in_range;
    logic       cmd_take, wr_take, rd_load, rd_fire, dummy_take;

    assign in_range = ({1'b0, addr} < NUM_REGS_W);

    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == i[6:0]) rd_byte = regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[8*g +: 8] = regs[g];
    end

    always_comb begin
        state_nxt  = state;
        cmd_take   = 1'b0;
        wr_take    = 1'b0;
        rd_load    = 1'b0;
        rd_fire    = 1'b0;
        dummy_take = 1'b0;
        if (cs_sync) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (armed) state_nxt = CMD;
                CMD: begin
                    if (si_done) begin
                        cmd_take  = 1'b1;
                        state_nxt = si_data[7] ? WR : RD_LOAD;
                    end
                end
                WR:      if (si_done) wr_take = 1'b1;
                RD_LOAD: begin
                    // so_data is loaded one cycle ahead so it is stable before the strobe
                    if (!loaded) begin
                        rd_load = 1'b1;
                    end else if (so_ready) begin
                        rd_fire   = 1'b1;
                        state_nxt = RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (si_done) begin
                        dummy_take = 1'b1;
                        state_nxt  = RD_LOAD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        so_start = rd_fire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cs_meta  <= 1'b1;
            cs_sync  <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
            addr     <= 7'd0;
            loaded   <= 1'b0;
            so_data  <= 8'h00;
            wr_pulse <= 1'b0;
            wr_addr  <= 7'd0;
            wr_data  <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            state    <= state_nxt;
            cs_meta  <= cs;
            cs_sync  <= cs_meta;
            sync_vld <= {sync_vld[0], 1'b1};
            // After reset, a frame is only accepted once cs is genuinely seen high
            if (sync_vld[1] && cs_sync) armed <= 1'b1;
            loaded   <= (state_nxt == RD_LOAD) && (loaded || rd_load);
            wr_pulse <= 1'b0;
            if (cmd_take) addr <= si_data[6:0];
            if (wr_take) begin
                addr <= addr + 7'd1;
                if (in_range) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr == i[6:0]) regs[i] <= si_data;
                    end
                    wr_pulse <= 1'b1;
                    wr_addr  <= addr;
                    wr_data  <= si_data;
                end
            end
            if (rd_load) so_data <= rd_byte;
            if (rd_fire) addr <= addr + 7'd1;
        end
    end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Scoreboard bench for spi_slave_regfile: expected writes and transmit loads are
// queued by the stimulus and retired by a monitor watching wr_pulse/so_start.
module tb_spi_slave_regfile;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cs = 1'b1;
    logic [7:0]      si_data = 8'h00;
    logic            si_done = 1'b0;
    logic [7:0]      so_data;
    logic            so_start;
    logic            so_ready = 1'b1;
    logic [8*NR-1:0] reg_q;
    logic            wr_pulse;
    logic [6:0]      wr_addr;
    logic [7:0]      wr_data;

    int errs = 0;
    int checks = 0;
    int start_cnt = 0;
    logic [14:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    spi_slave_regfile #(.NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset), .cs(cs), .si_data(si_data), .si_done(si_done),
        .so_data(so_data), .so_start(so_start), .so_ready(so_ready), .reg_q(reg_q),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (so_start && !so_ready) chk("so_start_while_not_ready", 32'(so_ready), 32'd1);
            if (wr_pulse) begin
                if (exp_wr.size() == 0) chk("unexpected_wr_pulse", {18'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
                else chk("wr_addr_data", {18'd0, wr_addr, wr_data}, {17'd0, exp_wr.pop_front()});
            end
            if (so_start) begin
                start_cnt++;
                if (exp_rd.size() == 0) chk("unexpected_so_start", {24'd0, so_data}, 32'hFFFF_FFFF);
                else chk("so_data_at_start", {24'd0, so_data}, {24'd0, exp_rd.pop_front()});
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        si_data = b;
        si_done = 1'b1;
        cycles(1);
        si_done = 1'b0;
        cycles(6);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        cycles(4);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        cycles(4);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_rd.size() != 0) && n < 50) begin
            cycles(1);
            n++;
        end
        chk({name, "_pending_expectations"}, 32'(exp_wr.size() + exp_rd.size()), 32'd0);
        exp_wr.delete();
        exp_rd.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        cycles(3);
        reset = 1'b0;
        #1;
        chk("rst_reg_q", reg_q, 32'h0);
        chk("rst_so_data", {24'd0, so_data}, 32'h0);
        chk("rst_so_start", {31'd0, so_start}, 32'h0);
        chk("rst_wr_pulse", {31'd0, wr_pulse}, 32'h0);
        chk("rst_wr_addr", {25'd0, wr_addr}, 32'h0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'h0);
        cycles(5);

        // write burst
        cs_low();
        exp_wr.push_back({7'd1, 8'hA5});
        exp_wr.push_back({7'd2, 8'h3C});
        send_byte(8'h81);
        send_byte(8'hA5);
        send_byte(8'h3C);
        cs_high();
        drain("write_burst");
        chk("write_burst_reg_q", reg_q, 32'h003C_A500);

        // read burst with so_ready held low before the first load
        so_ready = 1'b0;
        cs_low();
        base = start_cnt;
        exp_rd.push_back(8'hA5);
        send_byte(8'h01);
        cycles(4);
        chk("start_held_while_not_ready", 32'(start_cnt - base), 32'd0);
        so_ready = 1'b1;
        cycles(3);
        chk("start_after_ready", 32'(start_cnt - base), 32'd1);
        exp_rd.push_back(8'h3C);
        send_byte(8'h00);
        exp_rd.push_back(8'h00);
        send_byte(8'h00);
        cs_high();
        drain("read_burst");
        chk("read_burst_start_count", 32'(start_cnt - base), 32'd3);
        chk("read_burst_reg_q", reg_q, 32'h003C_A500);

        // address wrap and out-of-range
        cs_low();
        exp_wr.push_back({7'd0, 8'h66});
        send_byte(8'hFF);
        send_byte(8'h55);
        send_byte(8'h66);
        cs_high();
        cs_low();
        exp_rd.push_back(8'h00);
        send_byte(8'h10);
        cs_high();
        drain("wrap");
        chk("wrap_reg_q", reg_q, 32'h003C_A566);

        // aborted write frame, next frame starts with a fresh command
        cs_low();
        send_byte(8'h80);
        cs_high();
        cs_low();
        exp_rd.push_back(8'h00);
        send_byte(8'h42);
        cs_high();
        drain("abort");
        chk("abort_reg_q", reg_q, 32'h003C_A566);

        // si_done in the same cycle cs_sync rises during WR
        cs_low();
        send_byte(8'h81);
        cs = 1'b1;
        cycles(2);
        si_data = 8'h99;
        si_done = 1'b1;
        cycles(1);
        si_done = 1'b0;
        cycles(4);
        drain("collision");
        chk("collision_reg_q", reg_q, 32'h003C_A566);

        // reset in the middle of a write frame
        cs_low();
        exp_rd.push_back(8'hA5);
        send_byte(8'h01);
        cs_high();
        drain("pre_reset_read");
        chk("pre_reset_so_data", {24'd0, so_data}, 32'h0000_00A5);
        cs_low();
        exp_wr.push_back({7'd1, 8'hA5});
        send_byte(8'h81);
        send_byte(8'hA5);
        drain("pre_reset_write");
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        chk("mid_reset_reg_q", reg_q, 32'h0);
        chk("mid_reset_so_data", {24'd0, so_data}, 32'h0);
        send_byte(8'h11);
        send_byte(8'h22);
        cs_high();
        drain("post_reset");
        chk("post_reset_reg_q", reg_q, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
